// File: rtl/rv32i_system_unit.sv
// rv32i_system_unit
//   Handles SYSTEM-opcode instructions for an RV32I core: the read-only
//   cycle/time/instret counters, plus ECALL and EBREAK. It also holds a
//   two-state RUN/HALTED debug FSM. EBREAK halts the unit and resume restarts it.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_funct3/funct12  instruction fields; funct12 is the CSR address
//   cmd_rs1             register index or zimm
//   cmd_rs1_value       not used yet; kept for future writable CSRs
//   cmd_rd              destination register
//   retire              one-cycle pulse for each retired instruction
//   resp_valid/ready    response handshake (registered, held until ready)
//   resp_rd/value/cause cause: 0 none, 1 ECALL, 2 EBREAK, 3 illegal
//   halted, resume      debug halt status and restart pulse
module rv32i_system_unit #(
  parameter int TIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_funct3,
  input  logic [11:0] cmd_funct12,
  input  logic [4:0]  cmd_rs1,
  input  logic [31:0] cmd_rs1_value,
  input  logic [4:0]  cmd_rd,
  input  logic        retire,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_value,
  output logic [1:0]  resp_cause,
  output logic        halted,
  input  logic        resume
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
    logic [1:0]  cause;
  } resp_t;

  localparam logic [1:0] C_NONE = 2'd0, C_ECALL = 2'd1, C_EBREAK = 2'd2, C_ILL = 2'd3;
  localparam logic [15:0] PRESC_MAX = 16'(TIME_DIV - 1);

  logic [63:0] cycle_q, time_q, instret_q;
  logic [15:0] presc_q;
  state_t      state_q;
  resp_t       resp_q, resp_d;
  logic        resp_valid_q;
  logic        accept;

  // The operand value has no consumer until writable CSRs exist.
  logic        rs1_value_unused;
  assign rs1_value_unused = ^cmd_rs1_value;

  // rst is included so that ready stays low during reset, before the registers have settled.
  assign cmd_ready  = (!resp_valid_q || resp_ready) && !halted && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_q.rd;
  assign resp_value = resp_q.value;
  assign resp_cause = resp_q.cause;

  // Counters. A read on the acceptance cycle captures the pre-increment value
  // because decode below uses the current register contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      time_q    <= '0;
      instret_q <= '0;
      presc_q   <= '0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      instret_q <= instret_q + {63'd0, retire};
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
        time_q  <= time_q + 64'd1;
      end else begin
        presc_q <= presc_q + 16'd1;
      end
    end
  end

  // Decode the command into its response.
  logic        csr_hit;
  logic        csr_write;
  logic [31:0] csr_val;

  always_comb begin
    csr_hit = 1'b1;
    csr_val = '0;
    case (cmd_funct12)
      12'hC00: csr_val = cycle_q[31:0];
      12'hC80: csr_val = cycle_q[63:32];
      12'hC01: csr_val = time_q[31:0];
      12'hC81: csr_val = time_q[63:32];
      12'hC02: csr_val = instret_q[31:0];
      12'hC82: csr_val = instret_q[63:32];
      default: csr_hit = 1'b0;
    endcase
  end

  // The RW forms always write. The set/clear forms write only when rs1/zimm is nonzero.
  assign csr_write = (cmd_funct3 == 3'd1) || (cmd_funct3 == 3'd5) || (cmd_rs1 != 5'd0);

  always_comb begin
    resp_d = '0;
    case (cmd_funct3)
      3'd0: begin
        if (cmd_funct12 == 12'h000)      resp_d.cause = C_ECALL;
        else if (cmd_funct12 == 12'h001) resp_d.cause = C_EBREAK;
        else                             resp_d.cause = C_ILL;
      end
      3'd4: resp_d.cause = C_ILL;
      default: begin
        if (csr_write || !csr_hit) begin
          resp_d.cause = C_ILL;
        end else begin
          resp_d.cause = C_NONE;
          resp_d.rd    = cmd_rd;
          resp_d.value = csr_val;
        end
      end
    endcase
  end

  // Response register and RUN/HALTED FSM. The halt is taken when the EBREAK
  // response is consumed, not when it is accepted, so the core sees it first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      halted       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_q       <= resp_d;
      end else if (resp_valid_q && resp_ready) begin
        resp_valid_q <= 1'b0;
      end

      case (state_q)
        RUN: begin
          if (resp_valid_q && resp_ready && resp_q.cause == C_EBREAK) begin
            state_q <= HALTED;
            halted  <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state_q <= RUN;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_system_unit.sv
`timescale 1ns/1ps
module tb_rv32i_system_unit;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_funct3 = '0;
  logic [11:0] cmd_funct12 = '0;
  logic [4:0]  cmd_rs1 = '0;
  logic [31:0] cmd_rs1_value = '0;
  logic [4:0]  cmd_rd = '0;
  logic        retire = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [4:0]  resp_rd;
  logic [31:0] resp_value;
  logic [1:0]  resp_cause;
  logic        halted;
  logic        resume = 1'b0;

  rv32i_system_unit #(.TIME_DIV(TD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_funct3(cmd_funct3), .cmd_funct12(cmd_funct12), .cmd_rs1(cmd_rs1),
    .cmd_rs1_value(cmd_rs1_value), .cmd_rd(cmd_rd), .retire(retire),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_value(resp_value), .resp_cause(resp_cause),
    .halted(halted), .resume(resume)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
    logic [1:0]  cause;
  } exp_t;

  int n_checks = 0, n_fail = 0, n_acc = 0, n_hs = 0;
  exp_t exp_q[$];
  exp_t mon_e, last_e;

  // Reference counters, advanced per the counter rules at each rising edge.
  logic [63:0] m_cycle = '0, m_time = '0, m_instret = '0;
  int          m_presc = 0;

  function automatic exp_t expect_of(logic [2:0] f3, logic [11:0] a, logic [4:0] r1, logic [4:0] rdx);
    exp_t e;
    logic [63:0] src;
    logic found;
    e = '0;
    if (f3 == 3'd0) begin
      e.cause = (a == 12'h000) ? 2'd1 : (a == 12'h001) ? 2'd2 : 2'd3;
    end else if (f3 == 3'd4) begin
      e.cause = 2'd3;
    end else begin
      found = 1'b1;
      src = '0;
      if (a[6:0] == 7'h00)      src = m_cycle;
      else if (a[6:0] == 7'h01) src = m_time;
      else if (a[6:0] == 7'h02) src = m_instret;
      else                      found = 1'b0;
      if (a[11:7] != 5'b11000 && a[11:7] != 5'b11001) found = 1'b0;
      if (f3 == 3'd1 || f3 == 3'd5 || r1 != 5'd0 || !found) begin
        e.cause = 2'd3;
      end else begin
        e.rd = rdx;
        e.value = a[7] ? src[63:32] : src[31:0];
      end
    end
    return e;
  endfunction

  // Scoreboard: push at acceptance, pop and compare at response handshake.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cycle = '0; m_time = '0; m_instret = '0; m_presc = 0;
    end else begin
      if (resp_valid && resp_ready) begin
        n_hs++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected got rd=%0d value=%h cause=%0d, required no response", resp_rd, resp_value, resp_cause);
        end else begin
          mon_e = exp_q.pop_front();
          if ({resp_rd, resp_value, resp_cause} !== mon_e) begin
            n_fail++;
            $display("FAIL resp_data got rd=%0d value=%h cause=%0d, required rd=%0d value=%h cause=%0d",
                     resp_rd, resp_value, resp_cause, mon_e.rd, mon_e.value, mon_e.cause);
          end
          last_e = {resp_rd, resp_value, resp_cause};
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(expect_of(cmd_funct3, cmd_funct12, cmd_rs1, cmd_rd));
        n_acc++;
      end
      m_cycle = m_cycle + 64'd1;
      if (retire) m_instret = m_instret + 64'd1;
      if (m_presc == TD - 1) begin m_presc = 0; m_time = m_time + 64'd1; end
      else m_presc++;
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [4:0] rdx, input logic ret);
    int n;
    @(negedge clk);
    cmd_funct3 = f3; cmd_funct12 = a; cmd_rs1 = r1; cmd_rd = rdx;
    cmd_rs1_value = $urandom; retire = ret; cmd_valid = 1'b1;
    #1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL issue_timeout cmd_ready=%b, required 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; retire = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL drain_timeout pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({resp_valid, halted, cmd_ready, resp_rd, resp_value, resp_cause} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got valid=%b halted=%b ready=%b rd=%0d value=%h cause=%0d, required all 0",
               resp_valid, halted, cmd_ready, resp_rd, resp_value, resp_cause);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b, required 1", cmd_ready); end
  endtask

  task automatic test_cycle_read();
    repeat (9) @(negedge clk);
    issue(3'd2, 12'hC00, 5'd0, 5'd5, 1'b0);
    drain();
    n_checks++;
    if (last_e !== {5'd5, 32'd10, 2'd0}) begin
      n_fail++;
      $display("FAIL cycle_read got rd=%0d value=%0d cause=%0d, required rd=5 value=10 cause=0", last_e.rd, last_e.value, last_e.cause);
    end
  endtask

  task automatic test_time_instret();
    do_reset();
    repeat (16) @(negedge clk);
    issue(3'd2, 12'hC01, 5'd0, 5'd6, 1'b0);
    drain();
    n_checks++;
    if (last_e.value !== 32'd4) begin n_fail++; $display("FAIL time_read got %0d, required 4", last_e.value); end
    repeat (3) begin
      @(negedge clk); retire = 1'b1;
      @(negedge clk); retire = 1'b0;
    end
    issue(3'd2, 12'hC02, 5'd0, 5'd7, 1'b0);
    drain();
    n_checks++;
    if (last_e.value !== 32'd3) begin n_fail++; $display("FAIL instret_read got %0d, required 3", last_e.value); end
    // Retire coincident with the read must not be visible in the read.
    issue(3'd2, 12'hC02, 5'd0, 5'd8, 1'b1);
    drain();
    n_checks++;
    if (last_e.value !== 32'd3) begin n_fail++; $display("FAIL instret_coincident got %0d, required 3", last_e.value); end
  endtask

  task automatic test_illegal();
    logic [2:0]  f3 [8];
    logic [11:0] ad [8];
    logic [4:0]  r1 [8];
    logic [1:0]  ca [8];
    f3 = '{3'd1, 3'd6, 3'd2, 3'd4, 3'd0, 3'd3, 3'd7, 3'd5};
    ad = '{12'hC00, 12'hC80, 12'h300, 12'hC00, 12'h105, 12'hC82, 12'hC81, 12'hC01};
    r1 = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    ca = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3};
    for (int i = 0; i < 8; i++) begin
      issue(f3[i], ad[i], r1[i], 5'd9, 1'b0);
      drain();
      n_checks++;
      if (last_e.cause !== ca[i] || (ca[i] != 2'd0 && (last_e.value !== '0 || last_e.rd !== '0))) begin
        n_fail++;
        $display("FAIL illegal_%0d got cause=%0d value=%h rd=%0d, required cause=%0d", i, last_e.cause, last_e.value, last_e.rd, ca[i]);
      end
    end
  endtask

  task automatic test_halt();
    issue(3'd0, 12'h000, 5'd0, 5'd1, 1'b0);
    drain();
    n_checks++;
    if (last_e.cause !== 2'd1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL ecall got cause=%0d halted=%b, required cause=1 halted=0", last_e.cause, halted);
    end
    issue(3'd0, 12'h001, 5'd0, 5'd1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ebreak_halt got halted=%b ready=%b, required halted=1 ready=0", halted, cmd_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold got %b, required 1", halted); end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL resume got halted=%b ready=%b, required halted=0 ready=1", halted, cmd_ready);
    end
    // Counters kept running while halted.
    issue(3'd2, 12'hC00, 5'd0, 5'd2, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [6];
    logic [43:0] snap;
    int acc0, hs0;
    addrs = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    @(negedge clk);
    resp_ready = 1'b0;
    cmd_funct3 = 3'd2; cmd_funct12 = 12'hC02; cmd_rs1 = 5'd0; cmd_rd = 5'd7; cmd_valid = 1'b1;
    acc0 = n_acc;
    @(negedge clk);
    snap = {resp_rd, resp_value, resp_cause, resp_valid};
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({resp_rd, resp_value, resp_cause, resp_valid} !== snap || resp_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_stable got %h valid=%b, required %h valid=1", {resp_rd, resp_value, resp_cause}, resp_valid, snap[43:1]);
      end
    end
    n_checks++;
    if (n_acc - acc0 != 1) begin n_fail++; $display("FAIL stall_accepts got %0d, required 1", n_acc - acc0); end
    resp_ready = 1'b1;
    acc0 = n_acc; hs0 = n_hs;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %b, required 1", i, cmd_ready); end
      @(negedge clk);
      cmd_funct12 = addrs[i]; cmd_rd = 5'(i + 10);
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (n_acc - acc0 != 6 || n_hs - hs0 != 6) begin
      n_fail++; $display("FAIL b2b_rate got accepts=%0d responses=%0d, required 6 and 6", n_acc - acc0, n_hs - hs0);
    end
    drain();
  endtask

  task automatic test_wrap_and_reset();
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    m_cycle = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    issue(3'd2, 12'hC80, 5'd0, 5'd3, 1'b0);
    drain();
    n_checks++;
    if (last_e.value !== 32'd1) begin n_fail++; $display("FAIL wrap_high got %0d, required 1", last_e.value); end
    issue(3'd2, 12'hC00, 5'd0, 5'd4, 1'b0);
    drain();
    @(negedge clk);
    resp_ready = 1'b0;
    issue(3'd2, 12'hC00, 5'd0, 5'd4, 1'b0);
    n_checks++;
    if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL pending_before_rst got %b, required 1", resp_valid); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard got %b, required 0", resp_valid); end
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rst_no_resp got valid=%b pending=%0d, required 0", resp_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_cycle_read();
    test_time_instret();
    test_illegal();
    test_halt();
    test_back_to_back();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired, required test completion");
    $fatal(1);
  end

endmodule

// File: doc/rv32i_system_unit.md
RV32I_SYSTEM_UNIT -- requirements
Module: rv32i_system_unit

Interface
REQ-001 SHALL have parameter TIME_DIV, default 1, meaning the number of clk cycles per time-counter increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports cmd_valid input 1 and cmd_ready output 1, forming the command handshake.
REQ-005 SHALL have ports cmd_funct3 input 3, cmd_funct12 input 12, cmd_rs1 input 5 (register index or zimm), cmd_rs1_value input 32, and cmd_rd input 5, all fields of a SYSTEM-opcode instruction.
REQ-006 SHALL have port retire  input  1, a one-cycle pulse per retired instruction.
REQ-007 SHALL have ports resp_valid output 1 and resp_ready input 1, forming the response handshake.
REQ-008 SHALL have ports resp_rd output 5, resp_value output 32, and resp_cause output 2 (0 none, 1 ECALL, 2 EBREAK, 3 illegal).
REQ-009 SHALL have ports halted output 1 and resume input 1.

Function
REQ-010 SHALL maintain 64-bit counters cycle, time and instret, each wrapping from all-ones to zero.
REQ-011 cycle SHALL increment every clk cycle.
REQ-012 instret SHALL increment by 1 in every cycle in which retire=1.
REQ-013 time SHALL increment once every TIME_DIV cycles, driven by a prescaler counting 0..TIME_DIV-1.
REQ-014 A command SHALL be accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-015 cmd_ready SHALL equal (!resp_valid || resp_ready) && !halted.
REQ-016 The response SHALL be registered: resp_valid rises the cycle after acceptance and is held, with all resp_* fields stable, until resp_ready=1.
REQ-017 Back-to-back commands SHALL sustain one command per cycle when resp_ready is held at 1.
REQ-018 CSR read values SHALL be the counter value sampled on the acceptance cycle, before that cycle's increment.
REQ-019 Address mapping SHALL be: 0xC00/0xC80 = cycle low/high, 0xC01/0xC81 = time low/high, 0xC02/0xC82 = instret low/high.
REQ-020 A CSR op SHALL be a write attempt when it is CSRRW or CSRRWI, or when it is CSRRS/CSRRC/CSRRSI/CSRRCI with cmd_rs1 != 0.
REQ-021 A write attempt SHALL give cause=3, because all mapped CSRs are read-only.
REQ-022 An unmapped CSR address SHALL give cause=3.
REQ-023 funct3=4 SHALL give cause=3.
REQ-024 With funct3=0: funct12=0x000 SHALL give cause=1, funct12=0x001 SHALL give cause=2, and any other funct12 SHALL give cause=3.
REQ-025 When cause!=0, resp_value SHALL be 0 and resp_rd SHALL be 0.
REQ-026 When cause=0, resp_rd SHALL equal cmd_rd and resp_value SHALL be the selected CSR half.
REQ-027 cmd_rs1_value SHALL be ignored; it is kept for future writable CSRs.
REQ-028 The FSM SHALL have states RUN and HALTED.
REQ-029 RUN SHALL go to HALTED on the cycle an EBREAK response is accepted (resp_valid && resp_ready && cause=2).
REQ-030 HALTED SHALL return to RUN on the cycle resume=1; resume SHALL be ignored while in RUN.
REQ-031 halted SHALL be 1 exactly while in HALTED.
REQ-032 Counters SHALL keep counting while HALTED.
REQ-033 retire=1 coincident with command acceptance SHALL NOT affect the value returned by that command (REQ-018).

Reset
REQ-034 While rst=1, the block SHALL clear all counters and the prescaler to 0.
REQ-035 While rst=1, the block SHALL set resp_valid=0, resp_rd=0, resp_value=0, resp_cause=0, halted=0 and state=RUN, and SHALL hold cmd_ready=0.
REQ-036 rst asserted while a response is pending SHALL discard that response without a handshake.
REQ-037 The first rst-deasserted cycle SHALL have cmd_ready=1 and all counters at 0, which is the first counting cycle.

Verification
REQ-038 SHALL cover: release reset, hold 10 cycles, issue CSRRS rd=5 rs1=0 addr 0xC00 -> resp_rd=5, resp_value=10, cause=0.
REQ-039 SHALL cover: TIME_DIV=4, 17 cycles after reset, read 0xC01 -> resp_value=4; pulse retire 3 times, then read 0xC02 -> resp_value=3.
REQ-040 SHALL cover: CSRRW addr 0xC00, CSRRSI zimm=1 addr 0xC80, and CSRRS rs1=0 addr 0x300 -> cause=3 with resp_value=0 for each.
REQ-041 SHALL cover: ECALL -> cause=1, halted stays 0; EBREAK accepted -> halted=1 and cmd_ready=0 the next cycle; resume pulse -> halted=0 and cmd_ready=1 the following cycle.
REQ-042 SHALL cover: resp_ready held 0 for 5 cycles with cmd_valid=1 -> exactly one accept, resp_* stable throughout; then resp_ready=1 with continuous commands -> one response per cycle.
REQ-043 SHALL cover: preload cycle to 0x0000_0000_FFFF_FFFF via the simulation backdoor, step one cycle, read 0xC80 -> 1 and read 0xC00 -> the expected low word; rst asserted mid-response -> resp_valid=0 the next cycle.
